// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, serial line levels and a parity helper.
// Used by uart_tx and its sub-modules; the line-level constants are also meant for the
// receiver on the same uart_clk domain.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Parity over up to 9 data bits; unused upper bits must be zero.
  // odd = 0 gives even parity (XOR of the bits), odd = 1 gives its complement.
  function automatic logic uart_parity(logic [8:0] word, logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side word handshake for the UART transmitter.
//   tx_data  : word to send, sampled only when the transmitter accepts it
//   tx_valid : tx_data is valid
//   tx_ready : transmitter can accept a word (idle)
// master = word source, slave = transmitter.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and wraps; bit_end is high during the last cycle of each bit.
// Ports:
//   uart_clk : clock, all logic on posedge
//   rst_n    : synchronous active-low reset
//   clear    : synchronous clear, holds the counter at 0
//   bit_end  : last cycle of the current bit time
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic uart_clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_end = (cnt_q == CntMax);

  always_ff @(posedge uart_clk) begin
    if (!rst_n || clear) begin
      cnt_q <= '0;
    end else if (bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises DATA_WIDTH-bit words onto tx_out as
// start bit, LSB-first data, optional parity, STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data
// (even parity for PARITY_ODD = 0, odd for PARITY_ODD = 1).
// Ports:
//   uart_clk : clock, all logic on posedge
//   rst_n    : synchronous active-low reset; aborts any frame in progress
//   tx_if    : word handshake (tx_data / tx_valid in, tx_ready out, ready only in IDLE)
//   tx_out   : registered serial line, idles high
//   tx_busy  : frame in progress (~tx_ready)
//   tx_done  : one-cycle pulse in the cycle after the last stop-bit cycle
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  uart_tx_if.slave   tx_if,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CLKS_PER_BIT < 1 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : gen_bad_params
    $error("uart_tx: parameter out of range");
  end

  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_WIDTH - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  uart_tx_state_e        state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IdxW-1:0]       bit_idx_q;
  logic                  stop_cnt_q;
  logic                  tx_out_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  bit_end;
  logic                  accept;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  // Counter is held at zero while idle so the start bit gets a full bit time.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .uart_clk(uart_clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .bit_end (bit_end)
  );

  assign accept = tx_if.tx_valid && ready_q;

  always_ff @(posedge uart_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_out_q <= UART_IDLE_LEVEL;
          if (accept) begin
            state_q    <= START;
            shift_q    <= tx_if.tx_data;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_out_q   <= UART_START_BIT;
            ready_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            // Parity from the captured word; tx_data may change during the frame.
            parity_q   <= uart_parity(9'(tx_if.tx_data), PARITY_ODD != 0);
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            bit_idx_q <= '0;
            tx_out_q  <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
              state_q    <= PARITY;
              tx_out_q   <= parity_q;
`else
              state_q    <= STOP;
              tx_out_q   <= UART_STOP_BIT;
              stop_cnt_q <= 1'b0;
`endif
            end else begin
              // Next bit goes out now, so drive from bit 1 before the shift lands.
              shift_q   <= shift_q >> 1;
              tx_out_q  <= shift_q[1];
              bit_idx_q <= bit_idx_q + IdxW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            tx_out_q   <= UART_STOP_BIT;
            stop_cnt_q <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (stop_cnt_q == StopLast) begin
              state_q  <= IDLE;
              tx_out_q <= UART_IDLE_LEVEL;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          tx_out_q <= UART_IDLE_LEVEL;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_out         = tx_out_q;
  assign tx_busy        = ~ready_q;
  assign tx_done        = done_q;

endmodule
